dual_port_cmd_driver: RTL

Upstream command engine that feeds a DUT exposing two 8-bit valid/ready ports: a data-stream port (A) and an address-read port (B). Host commands enter a small FIFO and are executed one at a time on the selected port. The byte the DUT returns in the handshake cycle is delivered back on a response channel. It sits directly in front of the DUT and drives its valid/data/address inputs while consuming its ready and return-data outputs.

---
 rtl/dual_port_cmd_driver_pkg.sv | 24 ++
 rtl/dual_port_cmd_driver_cmd_fifo.sv | 49 ++++
 rtl/dual_port_cmd_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dual_port_cmd_driver_pkg.sv
// Shared types for the dual-port command driver: FSM states, op codes and
// the command word carried through the FIFO.
package dual_port_cmd_pkg;

   localparam int CMD_AW = 8;
   localparam int CMD_DW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_A = 2'd1,
      SEND_B = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic OP_STREAM = 1'b0;
   localparam logic OP_READ   = 1'b1;

   typedef struct packed {
      logic              op;
      logic [CMD_AW-1:0] addr;
      logic [CMD_DW-1:0] data;
   } cmd_t;

endpackage

// File: rtl/dual_port_cmd_driver_cmd_fifo.sv
// Command FIFO. Pointers carry one wrap bit above the index so full and
// empty are told apart without a separate occupancy counter.
module cmd_fifo
   import dual_port_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  cmd_t wdata,
   output cmd_t rdata,
   output logic full,
   output logic empty
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IW:0] wr_ptr;
   logic [IW:0] rd_ptr;
   cmd_t        mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
   assign rdata = mem[rd_ptr[IW-1:0]];

   // Pointer update; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care until pointed at by a push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IW-1:0]] <= wdata;
   end

endmodule

// File: rtl/dual_port_cmd_driver.sv
// Executes queued host commands one at a time on port A (stream write) or
// port B (address read) and returns the handshake-cycle byte to the host.
//
//   state  | meaning
//   IDLE   | waiting for a queued command; pops the head when one exists
//   SEND_A | a_valid_o high, waiting for a_ready_i
//   SEND_B | b_valid_o high, waiting for b_ready_i
//   RESP   | rsp_valid_o high, waiting for rsp_ready_i
module dual_port_cmd_driver
   import dual_port_cmd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 8,   // must match CMD_DW
   parameter int AW    = 8    // must match CMD_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_op_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_data_i,
   output logic          a_valid_o,
   output logic [DW-1:0] a_data_o,
   input  logic          a_ready_i,
   input  logic [DW-1:0] a_rdata_i,
   output logic          b_valid_o,
   output logic [AW-1:0] b_addr_o,
   input  logic          b_ready_i,
   input  logic [DW-1:0] b_rdata_i,
   output logic          rsp_valid_o,
   output logic          rsp_op_o,
   output logic [DW-1:0] rsp_data_o,
   input  logic          rsp_ready_i,
   output logic          busy_o
);

   cmd_t          push_cmd;
   cmd_t          head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   state_e        state;
   state_e        state_nxt;
   logic [DW-1:0] a_data;
   logic [AW-1:0] b_addr;
   logic          rsp_op;
   logic [DW-1:0] rsp_data;

   assign push_cmd = '{op: cmd_op_i, addr: cmd_addr_i, data: cmd_data_i};
   assign push     = cmd_valid_i && !full;

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_cmd),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and pop decode.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = (head.op == OP_READ) ? SEND_B : SEND_A;
            end
         end
         SEND_A:  if (a_ready_i)   state_nxt = RESP;
         SEND_B:  if (b_ready_i)   state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request payloads; each port keeps its last byte/address across the other op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_data <= '0;
         b_addr <= '0;
      end else if (pop) begin
         if (head.op == OP_STREAM) a_data <= head.data;
         else                      b_addr <= head.addr;
      end
   end

   // Response register, loaded only on the valid&&ready edge of the active port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_op   <= OP_STREAM;
         rsp_data <= '0;
      end else if ((state == SEND_A) && a_ready_i) begin
         rsp_op   <= OP_STREAM;
         rsp_data <= a_rdata_i;
      end else if ((state == SEND_B) && b_ready_i) begin
         rsp_op   <= OP_READ;
         rsp_data <= b_rdata_i;
      end
   end

   // Valids decode straight from state so reset drops them immediately.
   assign a_valid_o   = (state == SEND_A);
   assign b_valid_o   = (state == SEND_B);
   assign rsp_valid_o = (state == RESP);
   assign a_data_o    = a_data;
   assign b_addr_o    = b_addr;
   assign rsp_op_o    = rsp_op;
   assign rsp_data_o  = rsp_data;
   assign cmd_ready_o = !full;
   assign busy_o      = !empty || (state != IDLE);

endmodule
